// File: rtl/keypad_pkg.sv
// Shared types for the matrix keypad scanner.
// Frame classification codes and debounce FSM states.
package keypad_pkg;

    typedef enum logic [1:0] {
        FRAME_NONE   = 2'd0,
        FRAME_SINGLE = 2'd1,
        FRAME_MULTI  = 2'd2
    } frame_res_e;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } key_state_e;

    // Saturating hit count (0, 1, 2+) to frame result
    function automatic frame_res_e classify(input logic [1:0] hits);
        case (hits)
            2'd0:    return FRAME_NONE;
            2'd1:    return FRAME_SINGLE;
            default: return FRAME_MULTI;
        endcase
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous keypad row inputs.
// One independent chain per row bit.
module keypad_row_sync #(
    parameter int N_ROWS = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_ROWS-1:0] rows_async,
    output logic [N_ROWS-1:0] rows_sync
);

    logic [N_ROWS-1:0] meta_q, meta_d;
    logic [N_ROWS-1:0] sync_q, sync_d;

    // Next state of the two synchroniser stages
    always_comb begin
        meta_d = rows_async;
        sync_d = meta_q;
    end

    // Synchroniser registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rows_sync = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: one-hot column drive, per-frame row sampling,
// frame-level debounce and a press/release FSM with registered outputs.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int N_COLS         = 4,
    parameter int N_ROWS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int CODE_W         = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic [N_COLS-1:0] keyCols,
    input  logic [N_ROWS-1:0] keyRows,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              key_release,
    output logic              multi_key
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int STB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CODE_W-1:0] NO_KEY    = '1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLS - 1);
    localparam logic [STB_W-1:0]  STB_MAX   = STB_W'(DEBOUNCE_SCANS);

    logic [N_ROWS-1:0] rows_s;

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [N_COLS-1:0] cols_q, cols_d;
    logic [1:0]        hits_q, hits_d;
    logic [CODE_W-1:0] first_q, first_d;
    logic              fend_q, fend_d;

    frame_res_e        cand_q, cand_d;
    logic [CODE_W-1:0] cand_code_q, cand_code_d;
    logic [STB_W-1:0]  stable_q, stable_d;
    key_state_e        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              held_q, held_d;
    logic              rel_q, rel_d;
    logic              multi_q, multi_d;

    frame_res_e        res;
    logic [CODE_W-1:0] res_code;
    logic              same;
    logic [STB_W-1:0]  cnt_new;

    keypad_row_sync #(
        .N_ROWS(N_ROWS)
    ) u_sync (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rows_async(keyRows),
        .rows_sync (rows_s)
    );

    // Slot counter, column rotation and per-frame closure accumulation
    always_comb begin
        slot_d  = slot_q + SLOT_W'(1);
        col_d   = col_q;
        hits_d  = hits_q;
        first_d = first_q;
        fend_d  = 1'b0;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            col_d  = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            fend_d = (col_q == COL_LAST);
        end
        cols_d = N_COLS'(1) << col_d;
        if (fend_q) begin
            hits_d  = '0;
            first_d = NO_KEY;
        end else if (slot_q == SLOT_LAST) begin
            for (int r = 0; r < N_ROWS; r++) begin
                if (rows_s[r]) begin
                    if (hits_d == 2'd0)
                        first_d = CODE_W'(r * N_COLS) + CODE_W'(col_q);
                    if (hits_d != 2'd2)
                        hits_d = hits_d + 2'd1;
                end
            end
        end
    end

    // Frame result, debounce counter and press/release FSM
    always_comb begin
        res      = classify(hits_q);
        res_code = (res == FRAME_SINGLE) ? first_q : NO_KEY;
        same     = (res == cand_q) && (res_code == cand_code_q);
        if (!same)
            cnt_new = STB_W'(1);
        else if (stable_q == STB_MAX)
            cnt_new = STB_MAX;
        else
            cnt_new = stable_q + STB_W'(1);

        cand_d      = cand_q;
        cand_code_d = cand_code_q;
        stable_d    = stable_q;
        state_d     = state_q;
        code_d      = code_q;
        valid_d     = 1'b0;
        rel_d       = 1'b0;
        held_d      = held_q;
        multi_d     = multi_q;

        if (fend_q) begin
            multi_d     = (res == FRAME_MULTI);
            cand_d      = res;
            cand_code_d = res_code;
            stable_d    = cnt_new;
            unique case (state_q)
                ST_RELEASED: begin
                    if (res == FRAME_SINGLE && cnt_new == STB_MAX) begin
                        state_d  = ST_PRESSED;
                        code_d   = res_code;
                        valid_d  = 1'b1;
                        held_d   = 1'b1;
                        stable_d = '0;
                    end
                end
                ST_PRESSED: begin
                    // A different single key only releases; it must
                    // qualify again from scratch before being reported.
                    if (cnt_new == STB_MAX &&
                        (res == FRAME_NONE ||
                         (res == FRAME_SINGLE && res_code != code_q))) begin
                        state_d  = ST_RELEASED;
                        code_d   = NO_KEY;
                        rel_d    = 1'b1;
                        held_d   = 1'b0;
                        stable_d = '0;
                    end
                end
            endcase
        end
    end

    // Scan and accumulator registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q  <= '0;
            col_q   <= '0;
            cols_q  <= N_COLS'(1);
            hits_q  <= '0;
            first_q <= NO_KEY;
            fend_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            col_q   <= col_d;
            cols_q  <= cols_d;
            hits_q  <= hits_d;
            first_q <= first_d;
            fend_q  <= fend_d;
        end
    end

    // Debounce, FSM and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand_q      <= FRAME_NONE;
            cand_code_q <= NO_KEY;
            stable_q    <= '0;
            state_q     <= ST_RELEASED;
            code_q      <= NO_KEY;
            valid_q     <= 1'b0;
            rel_q       <= 1'b0;
            held_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cand_code_q <= cand_code_d;
            stable_q    <= stable_d;
            state_q     <= state_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            rel_q       <= rel_d;
            held_q      <= held_d;
            multi_q     <= multi_d;
        end
    end

    assign keyCols     = cols_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_held    = held_q;
    assign key_release = rel_q;
    assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: 4x4 pad, 4-clock slots, 3-frame debounce.
// Step table plus event scoreboard for key_valid / key_release pulses.
module tb_keypad_scan_debounce;

    localparam int FRAME = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] keyCols;
    logic [3:0] keyRows;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       key_release;
    logic       multi_key;
    logic [15:0] keys;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          ev;
        logic [4:0]  ev_code;
        logic [4:0]  code;
        logic        held;
        logic        multi;
    } step_t;

    typedef struct {
        int         ev;
        logic [4:0] code;
    } exp_t;

    step_t steps[18];
    exp_t  sbq[$];

    keypad_scan_debounce #(
        .N_COLS(4),
        .N_ROWS(4),
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3),
        .CODE_W(5)
    ) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .keyCols    (keyCols),
        .keyRows    (keyRows),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .key_release(key_release),
        .multi_key  (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key k closes row k/4 onto column k%4
    always_comb begin
        keyRows = '0;
        for (int r = 0; r < 4; r++)
            keyRows[r] = |(keys[r*4 +: 4] & keyCols);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if (key_valid || key_release) begin
            exp_t e;
            int   got;
            n_cmp++;
            got = key_valid ? 1 : 2;
            if (key_valid && key_release) begin
                n_err++;
                $display("FAIL strobe_overlap: valid and release both high at %0t", $time);
            end else if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got ev=%0d code=%0h expected none at %0t",
                         got, key_code, $time);
            end else begin
                e = sbq.pop_front();
                if (got != e.ev || key_code != e.code) begin
                    n_err++;
                    $display("FAIL strobe: got ev=%0d code=%0h expected ev=%0d code=%0h at %0t",
                             got, key_code, e.ev, e.code, $time);
                end
            end
        end
    end

    // Entered at the negedge of slot 1 of a frame; leaves at the same point
    task automatic run_step(input step_t s, input int idx);
        exp_t e;
        if (s.ev != 0) begin
            e.ev   = s.ev;
            e.code = s.ev_code;
            sbq.push_back(e);
        end
        keys = s.keys;
        repeat (s.frames * FRAME) @(posedge clk);
        @(negedge clk);
        check($sformatf("step%0d_code", idx), int'(key_code), int'(s.code));
        check($sformatf("step%0d_held", idx), int'(key_held), int'(s.held));
        check($sformatf("step%0d_multi", idx), int'(multi_key), int'(s.multi));
    endtask

    initial begin
        step_t s;
        int    exp_cols;
        n_cmp = 0;
        n_err = 0;

        // keys, frames, ev(0 none/1 valid/2 release), ev_code, code, held, multi
        steps[0]  = '{16'h0000, 2, 0, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[1]  = '{16'h0040, 3, 1, 5'h06, 5'h06, 1'b1, 1'b0};
        steps[2]  = '{16'h0040, 2, 0, 5'h1f, 5'h06, 1'b1, 1'b0};
        steps[3]  = '{16'h0000, 2, 0, 5'h1f, 5'h06, 1'b1, 1'b0};
        steps[4]  = '{16'h0000, 1, 2, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[5]  = '{16'h0040, 2, 0, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[6]  = '{16'h0000, 1, 0, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[7]  = '{16'h0021, 4, 0, 5'h1f, 5'h1f, 1'b0, 1'b1};
        steps[8]  = '{16'h0001, 2, 0, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[9]  = '{16'h0001, 1, 1, 5'h00, 5'h00, 1'b1, 1'b0};
        steps[10] = '{16'h0000, 3, 2, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[11] = '{16'h0040, 3, 1, 5'h06, 5'h06, 1'b1, 1'b0};
        steps[12] = '{16'h0200, 2, 0, 5'h1f, 5'h06, 1'b1, 1'b0};
        steps[13] = '{16'h0200, 1, 2, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[14] = '{16'h0200, 2, 0, 5'h1f, 5'h1f, 1'b0, 1'b0};
        steps[15] = '{16'h0200, 1, 1, 5'h09, 5'h09, 1'b1, 1'b0};
        steps[16] = '{16'h0208, 3, 0, 5'h1f, 5'h09, 1'b1, 1'b1};
        steps[17] = '{16'h0200, 1, 0, 5'h1f, 5'h09, 1'b1, 1'b0};

        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cols", int'(keyCols), 1);
        check("rst_code", int'(key_code), 'h1f);
        check("rst_strobes", int'({key_valid, key_held, key_release, multi_key}), 0);

        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_cols = 1 << ((k / 4) % 4);
            check($sformatf("rotate_slot%0d", k), int'(keyCols), exp_cols);
        end

        for (int i = 0; i < 18; i++)
            run_step(steps[i], i);

        // Reset while key 9 is held: immediate clear, no release strobe
        rst_n = 1'b0;
        #1;
        check("midrst_code", int'(key_code), 'h1f);
        check("midrst_held", int'(key_held), 0);
        check("midrst_cols", int'(keyCols), 1);
        check("midrst_strobes", int'({key_valid, key_release, multi_key}), 0);
        repeat (3) @(posedge clk);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s = '{16'h0000, 4, 0, 5'h1f, 5'h1f, 1'b0, 1'b0};
        run_step(s, 100);
        s = '{16'h0040, 3, 1, 5'h06, 5'h06, 1'b1, 1'b0};
        run_step(s, 101);

        repeat (2) @(negedge clk);
        check("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
